// File: rtl/mac_pkg.sv
// Shared definitions for the mac1 sequencer: FSM states and datapath widths.
package mac_pkg;

  localparam int MAC_DW          = 16;
  localparam int MAC_PW          = 32;
  localparam int MAC_LAT_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    DONE
  } mac_state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for the shared mac1 datapath.
// Flow: clear the accumulator, stream len operand pairs, flush the MAC
// pipeline with zero terms, then hold the result until it is consumed.
// Every output is a register; the comb block computes next-cycle values.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DW      = MAC_DW,
  parameter int PW      = MAC_PW,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [DW-1:0]    op_a,
  input  logic [DW-1:0]    op_b,
  output logic             mac_clr,
  output logic             mac_ce,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  input  logic [PW-1:0]    mac_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PW-1:0]    res_data
);

  // Drain counter runs 0..MAC_LAT; the final value marks the capture cycle.
  localparam int DCW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  mac_state_t       state, state_n;
  logic [LEN_W-1:0] len_q, len_q_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [DCW-1:0]   dcnt, dcnt_n;
  logic             busy_n, op_ready_n, mac_clr_n, mac_ce_n, res_valid_n;
  logic [DW-1:0]    mac_a_n, mac_b_n;
  logic [PW-1:0]    res_data_n;

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      op_ready  <= 1'b0;
      mac_clr   <= 1'b0;
      mac_ce    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_n;
      len_q     <= len_q_n;
      cnt       <= cnt_n;
      dcnt      <= dcnt_n;
      busy      <= busy_n;
      op_ready  <= op_ready_n;
      mac_clr   <= mac_clr_n;
      mac_ce    <= mac_ce_n;
      mac_a     <= mac_a_n;
      mac_b     <= mac_b_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
    end
  end

  // Next-state and next-output decode; pulses default low, data holds.
  always_comb begin
    state_n     = state;
    len_q_n     = len_q;
    cnt_n       = cnt;
    dcnt_n      = dcnt;
    busy_n      = busy;
    op_ready_n  = 1'b0;
    mac_clr_n   = 1'b0;
    mac_ce_n    = 1'b0;
    mac_a_n     = mac_a;
    mac_b_n     = mac_b;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    case (state)
      IDLE: begin
        if (start) begin
          busy_n = 1'b1;
          cnt_n  = '0;
          if (len != '0) begin
            len_q_n   = len;
            mac_clr_n = 1'b1;
            state_n   = CLR;
          end else begin
            // Empty job: nothing to accumulate, report zero without touching the MAC.
            res_data_n  = '0;
            res_valid_n = 1'b1;
            state_n     = DONE;
          end
        end
      end
      CLR: begin
        op_ready_n = 1'b1;
        state_n    = RUN;
      end
      RUN: begin
        op_ready_n = 1'b1;
        if (op_valid && op_ready) begin
          mac_ce_n = 1'b1;
          mac_a_n  = op_a;
          mac_b_n  = op_b;
          cnt_n    = cnt + 1'b1;
          if (cnt_n == len_q) begin
            op_ready_n = 1'b0;
            dcnt_n     = '0;
            state_n    = DRAIN;
          end
        end
      end
      DRAIN: begin
        // First DRAIN cycle issues the last pair; then MAC_LAT zero terms
        // push it through so mac_p is final by the capture cycle.
        if (dcnt == DCW'(MAC_LAT)) begin
          res_data_n  = mac_p;
          res_valid_n = 1'b1;
          state_n     = DONE;
        end else begin
          mac_ce_n = 1'b1;
          mac_a_n  = '0;
          mac_b_n  = '0;
          dcnt_n   = dcnt + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural two-stage mac1 model.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int DW = 16, PW = 32, LEN_W = 8, MAC_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, op_ready, mac_clr, mac_ce, res_valid;
  logic             op_valid = 1'b0;
  logic             res_ready = 1'b0;
  logic [DW-1:0]    op_a = '0, op_b = '0, mac_a, mac_b;
  logic [PW-1:0]    mac_p, res_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] va[4], vb[4];

  mac_seq_ctrl #(.DW(DW), .PW(PW), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_clr(mac_clr), .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b), .mac_p(mac_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // mac1 model: product register then accumulator; a term issued in cycle t
  // is visible on mac_p in cycle t+2. Not reset by rst_n.
  logic [PW-1:0] pv = '0, acc = '0;
  always @(posedge clk) begin
    if (mac_clr) begin
      pv  <= '0;
      acc <= '0;
    end else begin
      pv  <= mac_ce ? (PW'(mac_a) * PW'(mac_b)) : '0;
      acc <= acc + pv;
    end
  end
  assign mac_p = acc;

  // Event counters sampled mid-cycle.
  int n_ce = 0, n_nz = 0, n_clr = 0, n_res = 0;
  always @(negedge clk) begin
    if (mac_ce) n_ce++;
    if (mac_ce && (mac_a != '0 || mac_b != '0)) n_nz++;
    if (mac_clr) n_clr++;
    if (res_valid && res_ready) n_res++;
  end

  // Start a job, feed va/vb, wait for res_valid (not consumed).
  task automatic run_job(input int n, input bit alt, output logic [PW-1:0] r);
    int  i, cyc;
    bit  hs;
    start = 1'b1; len = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < n && cyc < 100) begin
      op_valid = alt ? ~cyc[0] : 1'b1;
      op_a = va[i]; op_b = vb[i];
      hs = op_valid & op_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) i++;
    end
    op_valid = 1'b0;
    checks++;
    if (op_ready !== 1'b0 || i != n) begin
      errors++;
      $display("FAIL feed: op_ready=%b pairs=%0d, want op_ready=0 pairs=%0d", op_ready, i, n);
    end
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    r = res_data;
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL res_timeout: res_valid=%b, want 1", res_valid);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL consume: res_valid=%b busy=%b, want 0 0", res_valid, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, op_ready, mac_clr, mac_ce, res_valid} !== 5'b0) begin
      errors++;
      $display("FAIL %s_ctl: busy/rdy/clr/ce/rv=%b, want 00000", tag,
               {busy, op_ready, mac_clr, mac_ce, res_valid});
    end
    checks++;
    if (mac_a !== '0 || mac_b !== '0 || res_data !== '0) begin
      errors++;
      $display("FAIL %s_data: mac_a=%h mac_b=%h res_data=%h, want 0", tag, mac_a, mac_b, res_data);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_release");
  endtask

  task automatic test_stream(input bit alt);
    logic [PW-1:0] r;
    int ce0, nz0, rs0;
    va = '{16'd1, 16'd2, 16'd3, 16'd4};
    vb = '{16'd10, 16'd10, 16'd10, 16'd0};
    ce0 = n_ce; nz0 = n_nz; rs0 = n_res;
    run_job(4, alt, r);
    checks++;
    if (r !== 32'd60) begin
      errors++; $display("FAIL stream%0d_res: got %0d, want 60", alt, r);
    end
    consume();
    checks++;
    if (n_nz - nz0 != 4 || n_ce - ce0 != 6) begin
      errors++;
      $display("FAIL stream%0d_ce: nonzero=%0d total=%0d, want 4 6", alt, n_nz - nz0, n_ce - ce0);
    end
    checks++;
    if (n_res - rs0 != 1) begin
      errors++; $display("FAIL stream%0d_res_count: got %0d, want 1", alt, n_res - rs0);
    end
  endtask

  task automatic test_len0();
    int ce0, clr0;
    ce0 = n_ce; clr0 = n_clr;
    start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL len0: rv=%b data=%h busy=%b, want 1 0 1", res_valid, res_data, busy);
    end
    consume();
    checks++;
    if (n_ce != ce0 || n_clr != clr0) begin
      errors++;
      $display("FAIL len0_mac: ce=%0d clr=%0d, want 0 0", n_ce - ce0, n_clr - clr0);
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] r;
    int clr0;
    va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
    run_job(1, 1'b0, r);
    checks++;
    if (r !== 32'hFFFE0001) begin
      errors++; $display("FAIL wrap1: got %h, want fffe0001", r);
    end
    consume();
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
    clr0 = n_clr;
    run_job(2, 1'b0, r);
    checks++;
    if (r !== 32'hFFFC0002) begin
      errors++; $display("FAIL wrap2: got %h, want fffc0002", r);
    end
    checks++;
    if (n_clr - clr0 != 1) begin
      errors++; $display("FAIL wrap2_clr: got %0d clears, want 1", n_clr - clr0);
    end
    consume();
  endtask

  task automatic test_done_hold();
    logic [PW-1:0] r;
    va[0] = 16'd2; vb[0] = 16'd3;
    run_job(1, 1'b0, r);
    checks++;
    if (r !== 32'd6) begin
      errors++; $display("FAIL hold_res: got %0d, want 6", r);
    end
    for (int k = 0; k < 10; k++) begin
      start = (k % 3 == 0); len = 8'd5;
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd6 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_c%0d: rv=%b data=%0d busy=%b, want 1 6 1", k, res_valid, res_data, busy);
      end
    end
    start = 1'b0;
    consume();
    // Start in the first IDLE cycle must be taken.
    start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== '0) begin
      errors++;
      $display("FAIL hold_restart: rv=%b busy=%b data=%h, want 1 1 0", res_valid, busy, res_data);
    end
    consume();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL hold_noqueue%0d: busy=%b, want 0", k, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] r;
    int  i, cyc;
    bit  hs;
    va = '{16'd1, 16'd2, 16'd3, 16'd4};
    vb = '{16'd7, 16'd7, 16'd7, 16'd7};
    start = 1'b1; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < 2 && cyc < 50) begin
      op_valid = 1'b1; op_a = va[i]; op_b = vb[i];
      hs = op_valid & op_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) i++;
    end
    op_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || mac_ce !== 1'b1) begin
      errors++; $display("FAIL mid_prereset: busy=%b ce=%b, want 1 1", busy, mac_ce);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    va[0] = 16'd5; vb[0] = 16'd5; va[1] = 16'd6; vb[1] = 16'd6;
    run_job(2, 1'b0, r);
    checks++;
    if (r !== 32'd61) begin
      errors++; $display("FAIL mid_rerun: got %0d, want 61", r);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_len0();
    test_wrap();
    test_done_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
